// File: rtl/vector_pkg.sv
// Shared vector-unit widths, FSM state type and operand beat layout,
// common to the VRF read and writeback sequencers.
package vector_pkg;
    localparam int els_c   = 32;
    localparam int vlen_c  = 8;
    localparam int vdw_c   = 32;
    localparam int lanes_c = 4;

    localparam int v_addr_width     = $clog2(els_c);
    localparam int local_addr_width = $clog2(vlen_c);
    localparam int vl_width         = $clog2(vlen_c + 1);

    typedef struct packed {
        logic [lanes_c*vdw_c-1:0] op0;
        logic [lanes_c*vdw_c-1:0] op1;
        logic [lanes_c-1:0]       mask;
        logic                     last;
    } op_beat_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } rd_state_e;
endpackage

// File: rtl/vrf_rd_seq_if.sv
// Operand beat channel from the read sequencer to the lane datapath.
interface vrf_rd_seq_if;
    import vector_pkg::*;

    logic                     valid;
    logic                     ready;
    logic [lanes_c*vdw_c-1:0] op0;
    logic [lanes_c*vdw_c-1:0] op1;
    logic [lanes_c-1:0]       mask;
    logic                     last;

    modport master (output valid, op0, op1, mask, last, input ready);
    modport slave  (input valid, op0, op1, mask, last, output ready);
endinterface

// File: rtl/vrf_rd_out_reg.sv
// Single-entry valid/ready output register: loads on enable, drops valid
// once the consumer takes the beat and nothing new is loaded.
module vrf_rd_out_reg
    import vector_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  op_beat_t            beat,
    vrf_rd_seq_if.master        op
);
    op_beat_t beat_reg;
    logic     valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            beat_reg  <= '0;
        end else if (load) begin
            valid_reg <= 1'b1;
            beat_reg  <= beat;
        end else if (op.ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign op.valid = valid_reg;
    assign op.op0   = beat_reg.op0;
    assign op.op1   = beat_reg.op1;
    assign op.mask  = beat_reg.mask;
    assign op.last  = beat_reg.last;
endmodule

// File: rtl/vrf_rd_seq.sv
// VRF operand read sequencer: walks one instruction's vector in lane-wide
// beats, addresses the VRF per lane and registers the returned operands.
module vrf_rd_seq
    import vector_pkg::*;
#(
    parameter int els_p   = els_c,
    parameter int vlen_p  = vlen_c,
    parameter int vdw_p   = vdw_c,
    parameter int lanes_p = lanes_c
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic                                cmd_v_i,
    output logic                                cmd_ready_o,
    input  logic [$clog2(els_p)-1:0]            cmd_vs0_i,
    input  logic [$clog2(els_p)-1:0]            cmd_vs1_i,
    input  logic [$clog2(vlen_p+1)-1:0]         cmd_vl_i,
    output logic [lanes_p*$clog2(els_p)-1:0]    r_reg0_addr_o,
    output logic [lanes_p*$clog2(els_p)-1:0]    r_reg1_addr_o,
    output logic [lanes_p*$clog2(vlen_p)-1:0]   r_addr_o,
    input  logic [lanes_p*vdw_p-1:0]            r0_data_i,
    input  logic [lanes_p*vdw_p-1:0]            r1_data_i,
    output logic                                op_v_o,
    input  logic                                op_ready_i,
    output logic [lanes_p*vdw_p-1:0]            op0_data_o,
    output logic [lanes_p*vdw_p-1:0]            op1_data_o,
    output logic [lanes_p-1:0]                  op_mask_o,
    output logic                                op_last_o
);
    localparam int aw = $clog2(els_p);
    localparam int ew = $clog2(vlen_p);
    localparam int lw = $clog2(vlen_p + 1);
    localparam int bw = $clog2(vlen_p / lanes_p + 1);

    rd_state_e        state_reg, state_next;
    logic [bw-1:0]    beat_reg, beat_next;
    logic [aw-1:0]    vs0_reg, vs1_reg;
    logic [lw-1:0]    vl_reg, vl_eff, beats;
    logic             run, accept, load, last_beat;
    logic [lanes_p-1:0] active;
    logic [lw-1:0]    elem [lanes_p];
    op_beat_t         beat_d;

    vrf_rd_seq_if op_bus ();

    assign run         = (state_reg == ST_RUN);
    assign cmd_ready_o = (state_reg == ST_IDLE);
    assign accept      = cmd_v_i & cmd_ready_o;
    assign load        = run & (~op_bus.valid | op_ready_i);
    assign vl_eff      = (cmd_vl_i > lw'(vlen_p)) ? lw'(vlen_p) : cmd_vl_i;
    // Widen by one bit so vl + lanes-1 cannot wrap before the divide.
    assign beats       = lw'(({1'b0, vl_reg} + (lw+1)'(lanes_p - 1)) / (lw+1)'(lanes_p));
    assign last_beat   = (lw'(beat_reg) == beats - lw'(1));

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_reg <= ST_IDLE;
            beat_reg  <= '0;
            vs0_reg   <= '0;
            vs1_reg   <= '0;
            vl_reg    <= '0;
        end else begin
            state_reg <= state_next;
            beat_reg  <= beat_next;
            if (accept) begin
                vs0_reg <= cmd_vs0_i;
                vs1_reg <= cmd_vs1_i;
                vl_reg  <= vl_eff;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        beat_next  = beat_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept && vl_eff != '0) begin
                    state_next = ST_RUN;
                    beat_next  = '0;
                end
            end
            ST_RUN: begin
                if (load) begin
                    beat_next = beat_reg + bw'(1);
                    if (last_beat) state_next = ST_IDLE;
                end
            end
        endcase
    end

    for (genvar gi = 0; gi < lanes_p; gi++) begin : g_lane
        assign elem[gi]   = lw'(beat_reg) * lw'(lanes_p) + lw'(gi);
        assign active[gi] = (elem[gi] < vl_reg);

        assign r_addr_o[gi*ew +: ew]      = run ? elem[gi][ew-1:0] : '0;
        assign r_reg0_addr_o[gi*aw +: aw] = run ? vs0_reg : '0;
        assign r_reg1_addr_o[gi*aw +: aw] = run ? vs1_reg : '0;

        // Lanes past the vector length carry zeros rather than stale VRF data.
        assign beat_d.op0[gi*vdw_p +: vdw_p] = active[gi] ? r0_data_i[gi*vdw_p +: vdw_p] : '0;
        assign beat_d.op1[gi*vdw_p +: vdw_p] = active[gi] ? r1_data_i[gi*vdw_p +: vdw_p] : '0;
    end

    assign beat_d.mask = active;
    assign beat_d.last = last_beat;

    vrf_rd_out_reg u_out_reg (
        .clk   (clk_i),
        .rst_n (reset_i),
        .load  (load),
        .beat  (beat_d),
        .op    (op_bus.master)
    );

    assign op_bus.ready = op_ready_i;
    assign op_v_o       = op_bus.valid;
    assign op0_data_o   = op_bus.op0;
    assign op1_data_o   = op_bus.op1;
    assign op_mask_o    = op_bus.mask;
    assign op_last_o    = op_bus.last;
endmodule

// File: tb/tb_vrf_rd_seq.sv
// Directed bench for vrf_rd_seq with a combinational VRF model (reg r, elem e -> r*16+e).
module tb_vrf_rd_seq;
    import vector_pkg::*;

    logic         clk = 1'b0;
    logic         reset_i = 1'b1;
    logic         cmd_v = 1'b0;
    logic         cmd_ready;
    logic [4:0]   cmd_vs0 = '0, cmd_vs1 = '0;
    logic [3:0]   cmd_vl = '0;
    logic [19:0]  r_reg0_addr, r_reg1_addr;
    logic [11:0]  r_addr;
    logic [127:0] r0_data, r1_data;

    vrf_rd_seq_if mon ();

    vrf_rd_seq dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .cmd_v_i       (cmd_v),
        .cmd_ready_o   (cmd_ready),
        .cmd_vs0_i     (cmd_vs0),
        .cmd_vs1_i     (cmd_vs1),
        .cmd_vl_i      (cmd_vl),
        .r_reg0_addr_o (r_reg0_addr),
        .r_reg1_addr_o (r_reg1_addr),
        .r_addr_o      (r_addr),
        .r0_data_i     (r0_data),
        .r1_data_i     (r1_data),
        .op_v_o        (mon.valid),
        .op_ready_i    (mon.ready),
        .op0_data_o    (mon.op0),
        .op1_data_o    (mon.op1),
        .op_mask_o     (mon.mask),
        .op_last_o     (mon.last)
    );

    always #5 clk = ~clk;

    always_comb begin
        r0_data = '0;
        r1_data = '0;
        for (int l = 0; l < 4; l++) begin
            r0_data[l*32 +: 32] = 32'(r_reg0_addr[l*5 +: 5]) * 32'd16 + 32'(r_addr[l*3 +: 3]);
            r1_data[l*32 +: 32] = 32'(r_reg1_addr[l*5 +: 5]) * 32'd16 + 32'(r_addr[l*3 +: 3]);
        end
    end

    typedef struct {
        int           cyc;
        logic [127:0] d0;
        logic [127:0] d1;
        logic [3:0]   m;
        logic         l;
    } rec_t;

    rec_t q[$];
    int   cyc = 0;
    int   vseen = 0;
    int   errors = 0;
    int   checks = 0;
    int   c0;

    localparam logic [127:0] D30   = 128'h00000033_00000032_00000031_00000030;
    localparam logic [127:0] D34   = 128'h00000037_00000036_00000035_00000034;
    localparam logic [127:0] D50   = 128'h00000053_00000052_00000051_00000050;
    localparam logic [127:0] D54   = 128'h00000057_00000056_00000055_00000054;
    localparam logic [127:0] D34V6 = 128'h00000000_00000000_00000035_00000034;
    localparam logic [127:0] D54V6 = 128'h00000000_00000000_00000055_00000054;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon.valid) vseen++;
        if (mon.valid && mon.ready && reset_i)
            q.push_back('{cyc, mon.op0, mon.op1, mon.mask, mon.last});
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] vs0, input logic [4:0] vs1, input logic [3:0] vl);
        cmd_vs0 = vs0;
        cmd_vs1 = vs1;
        cmd_vl  = vl;
        cmd_v   = 1'b1;
        step(1);
        cmd_v   = 1'b0;
    endtask

    task automatic check_beat(input string tag, input int idx, input int exp_cyc,
                              input logic [127:0] d0, input logic [127:0] d1,
                              input logic [3:0] m, input logic l);
        if (idx >= q.size()) begin
            chk({tag, "_present"}, 128'(q.size()), 128'(idx + 1));
        end else begin
            if (exp_cyc >= 0) chk({tag, "_cycle"}, 128'(q[idx].cyc), 128'(exp_cyc));
            chk({tag, "_op0"},  q[idx].d0, d0);
            chk({tag, "_op1"},  q[idx].d1, d1);
            chk({tag, "_mask"}, 128'(q[idx].m), 128'(m));
            chk({tag, "_last"}, 128'(q[idx].l), 128'(l));
        end
    endtask

    initial begin
        mon.ready = 1'b1;
        #2 reset_i = 1'b0;
        step(2);
        chk("rst_op_v",  128'(mon.valid), 0);
        chk("rst_mask",  128'(mon.mask), 0);
        chk("rst_last",  128'(mon.last), 0);
        chk("rst_op0",   mon.op0, 0);
        chk("rst_raddr", 128'(r_addr), 0);
        chk("rst_reg0",  128'(r_reg0_addr), 0);
        reset_i = 1'b1;
        step(1);
        chk("rst_cmd_ready", 128'(cmd_ready), 1);

        // Full-length vector, consumer always ready.
        q.delete(); c0 = cyc;
        send(5'd3, 5'd5, 4'd8);
        chk("full_ready_c1", 128'(cmd_ready), 0);
        chk("full_reg0_c1", 128'(r_reg0_addr), 128'h18C63);
        chk("full_reg1_c1", 128'(r_reg1_addr), 128'h294A5);
        step(1);
        chk("full_ready_c2", 128'(cmd_ready), 0);
        step(1);
        chk("full_ready_c3", 128'(cmd_ready), 1);
        step(3);
        chk("full_nbeats", 128'(q.size()), 2);
        check_beat("full_b0", 0, c0 + 2, D30, D50, 4'hF, 1'b0);
        check_beat("full_b1", 1, c0 + 3, D34, D54, 4'hF, 1'b1);

        // Partial final beat.
        q.delete(); c0 = cyc;
        send(5'd3, 5'd5, 4'd6);
        step(4);
        chk("vl6_nbeats", 128'(q.size()), 2);
        check_beat("vl6_b0", 0, c0 + 2, D30, D50, 4'hF, 1'b0);
        check_beat("vl6_b1", 1, c0 + 3, D34V6, D54V6, 4'h3, 1'b1);

        // Back-pressure in cycles 2..4.
        q.delete(); c0 = cyc;
        mon.ready = 1'b0;
        send(5'd3, 5'd5, 4'd8);
        step(1);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("stall_v_c%0d", k + 2),    128'(mon.valid), 1);
            chk($sformatf("stall_op0_c%0d", k + 2),  mon.op0, D30);
            chk($sformatf("stall_op1_c%0d", k + 2),  mon.op1, D50);
            chk($sformatf("stall_last_c%0d", k + 2), 128'(mon.last), 0);
            chk($sformatf("stall_raddr_c%0d", k + 2), 128'(r_addr), 128'hFAC);
            step(1);
        end
        mon.ready = 1'b1;
        step(1);
        chk("stall_b1_v",    128'(mon.valid), 1);
        chk("stall_b1_op0",  mon.op0, D34);
        chk("stall_b1_last", 128'(mon.last), 1);
        step(3);
        chk("stall_nbeats", 128'(q.size()), 2);
        check_beat("stall_b0", 0, c0 + 5, D30, D50, 4'hF, 1'b0);
        check_beat("stall_b1", 1, c0 + 6, D34, D54, 4'hF, 1'b1);

        // Zero-length command produces nothing.
        vseen = 0;
        send(5'd3, 5'd5, 4'd0);
        step(5);
        chk("vl0_vseen", 128'(vseen), 0);
        chk("vl0_ready", 128'(cmd_ready), 1);

        // Over-length vector is clamped to vlen.
        q.delete(); c0 = cyc;
        send(5'd3, 5'd5, 4'd11);
        step(5);
        chk("vl11_nbeats", 128'(q.size()), 2);
        check_beat("vl11_b0", 0, c0 + 2, D30, D50, 4'hF, 1'b0);
        check_beat("vl11_b1", 1, c0 + 3, D34, D54, 4'hF, 1'b1);

        // Second command accepted while the first one's last beat is held.
        q.delete(); c0 = cyc;
        send(5'd3, 5'd5, 4'd4);
        step(1);
        chk("b2b_v_c2",     128'(mon.valid), 1);
        chk("b2b_ready_c2", 128'(cmd_ready), 1);
        send(5'd5, 5'd3, 4'd4);
        step(3);
        chk("b2b_nbeats", 128'(q.size()), 2);
        check_beat("b2b_b0", 0, c0 + 2, D30, D50, 4'hF, 1'b1);
        check_beat("b2b_b1", 1, -1, D50, D30, 4'hF, 1'b1);

        // Asynchronous reset while a beat is on the output.
        q.delete(); c0 = cyc;
        send(5'd3, 5'd5, 4'd8);
        step(1);
        chk("mid_v_before", 128'(mon.valid), 1);
        #2 reset_i = 1'b0;
        #1;
        chk("mid_v_async",    128'(mon.valid), 0);
        chk("mid_mask_async", 128'(mon.mask), 0);
        step(1);
        reset_i = 1'b1;
        step(1);
        chk("mid_ready", 128'(cmd_ready), 1);
        chk("mid_raddr", 128'(r_addr), 0);
        chk("mid_reg0",  128'(r_reg0_addr), 0);
        step(3);
        chk("mid_nbeats", 128'(q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
